vpu2_acc: RTL and testbench

- Downstream stage of the VPU2 MulAcc datapath.
- Consumes the two-lane modular result bus, `dout0`/`dout1`, and accumulates a programmed number of valid beats per lane, modulo MOD.
- Presents the final two-lane sum to the writeback stage through a valid/ready handshake.
- Turns per-element multiply-add results into dot-product/reduction results for the VPU2 controller.

---
 rtl/vpu2_acc.sv | 130 +++++++++++++
 tb/tb_vpu2_acc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu2_acc.sv
// vpu2_acc: two-lane modular accumulator behind the VPU2 MulAcc datapath.
// Optional input/protocol checking with o_acc_err under `VPU2_ACC_CHK_EN.
module vpu2_acc #(
  parameter int unsigned        DWIDTH = 39,
  parameter logic [DWIDTH-1:0]  MOD    = 39'h40_0080_0001,
  parameter int unsigned        CNTW   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_acc_start,
  input  logic [CNTW-1:0]       i_acc_len,
  input  logic                  i_acc_vld,
  input  logic [2*DWIDTH-1:0]   i_acc_din,
  output logic                  o_acc_busy,
  output logic                  o_acc_vld,
  input  logic                  i_acc_rdy,
  output logic [2*DWIDTH-1:0]   o_acc_dout
`ifdef VPU2_ACC_CHK_EN
  ,
  output logic                  o_acc_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  logic [DWIDTH-1:0] acc0;
  logic [DWIDTH-1:0] acc1;
  logic [CNTW-1:0]   cnt;
  logic [CNTW-1:0]   len_q;

  logic [DWIDTH-1:0] din0;
  logic [DWIDTH-1:0] din1;
  logic [DWIDTH:0]   s0;
  logic [DWIDTH:0]   s1;
  logic [DWIDTH:0]   m_ext;
  logic [DWIDTH-1:0] nxt0;
  logic [DWIDTH-1:0] nxt1;
  logic              last;

  assign din0  = i_acc_din[DWIDTH-1:0];
  assign din1  = i_acc_din[2*DWIDTH-1:DWIDTH];
  assign m_ext = {1'b0, MOD};
  assign last  = (cnt == len_q - CNTW'(1));

  // Operands are < MOD, so one conditional subtract fully reduces the sum.
  always_comb begin
    s0   = {1'b0, acc0} + {1'b0, din0};
    s1   = {1'b0, acc1} + {1'b0, din1};
    nxt0 = DWIDTH'((s0 >= m_ext) ? s0 - m_ext : s0);
    nxt1 = DWIDTH'((s1 >= m_ext) ? s1 - m_ext : s1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc0       <= '0;
      acc1       <= '0;
      cnt        <= '0;
      len_q      <= '0;
      o_acc_busy <= 1'b0;
      o_acc_vld  <= 1'b0;
      o_acc_dout <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_acc_start) begin
            acc0       <= '0;
            acc1       <= '0;
            cnt        <= '0;
            len_q      <= i_acc_len;
            o_acc_busy <= 1'b1;
            if (i_acc_len != '0) begin
              state <= ACC;
            end else begin
              state      <= HOLD;
              o_acc_vld  <= 1'b1;
              o_acc_dout <= '0;
            end
          end
        end
        ACC: begin
          if (i_acc_vld) begin
            acc0 <= nxt0;
            acc1 <= nxt1;
            cnt  <= cnt + CNTW'(1);
            if (last) begin
              state      <= HOLD;
              o_acc_vld  <= 1'b1;
              o_acc_dout <= {nxt1, nxt0};
            end
          end
        end
        HOLD: begin
          if (i_acc_rdy) begin
            state      <= IDLE;
            o_acc_vld  <= 1'b0;
            o_acc_busy <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          o_acc_vld  <= 1'b0;
          o_acc_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef VPU2_ACC_CHK_EN
  logic chk;

  // Flags protocol misuse and out-of-range lanes; the beat itself is
  // still handled exactly as in the unchecked build.
  assign chk = (i_acc_vld && state != ACC)
             || (i_acc_start && state != IDLE)
             || (i_acc_vld && state == ACC
                 && (din0 >= MOD || din1 >= MOD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_acc_err <= 1'b0;
    else if (chk) o_acc_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_vpu2_acc.sv
// tb_vpu2_acc: randomized run-level bench for vpu2_acc.
// Reference sums use plain modular arithmetic on 64-bit integers.
module tb_vpu2_acc;

  localparam int DW = 39;
  localparam int CW = 8;
  localparam longint unsigned M = 64'h40_0080_0001;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CW-1:0]     len_i = '0;
  logic              vld_i = 1'b0;
  logic [2*DW-1:0]   din = '0;
  logic              busy;
  logic              vld_o;
  logic              rdy = 1'b0;
  logic [2*DW-1:0]   dout;
`ifdef VPU2_ACC_CHK_EN
  logic              err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit junk = 1'b1;
  logic [2*DW-1:0] last_exp;
  longint unsigned q0[$];
  longint unsigned q1[$];

  vpu2_acc dut (
    .clk         (clk),
    .rst         (rst),
    .i_acc_start (start),
    .i_acc_len   (len_i),
    .i_acc_vld   (vld_i),
    .i_acc_din   (din),
    .o_acc_busy  (busy),
    .o_acc_vld   (vld_o),
    .i_acc_rdy   (rdy),
    .o_acc_dout  (dout)
`ifdef VPU2_ACC_CHK_EN
    ,
    .o_acc_err   (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [2*DW-1:0] got,
                       logic [2*DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic longint unsigned rnd_lane();
    longint unsigned r;
    r = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0)
      return M - 1 - longint'($urandom_range(0, 3));
    return r % M;
  endfunction

  function automatic logic [2*DW-1:0] pack(longint unsigned a,
                                           longint unsigned b);
    logic [63:0] x;
    logic [63:0] y;
    x = a;
    y = b;
    return {y[DW-1:0], x[DW-1:0]};
  endfunction

  task automatic junk_beat();
    vld_i = junk && ($urandom_range(0, 1) == 1);
    din   = pack(rnd_lane(), rnd_lane());
  endtask

  // gap: 0 = back-to-back, 1 = alternating, 2 = random gaps/noise
  task automatic run(int len, int gap, int hold);
    longint unsigned s0 = 0;
    longint unsigned s1 = 0;
    longint unsigned d0;
    longint unsigned d1;
    int beats = 0;
    int tries = 0;
    bit v;
    start = 1'b1;
    len_i = CW'(len);
    cyc();
    start = 1'b0;
    if (len != 0) begin
      check("start_busy", 78'(busy), 78'(1));
      check("start_vld", 78'(vld_o), 78'(0));
    end
    while (beats < len) begin
      if (gap == 0) v = 1'b1;
      else if (gap == 1) v = (tries % 2 == 0);
      else v = ($urandom_range(0, 2) != 0);
      tries++;
      if (v) begin
        d0 = (q0.size() > 0) ? q0.pop_front() : rnd_lane();
        d1 = (q1.size() > 0) ? q1.pop_front() : rnd_lane();
        s0 = (s0 + d0) % M;
        s1 = (s1 + d1) % M;
        din = pack(d0, d1);
        beats++;
      end else begin
        din = pack(rnd_lane(), rnd_lane());
      end
      vld_i = v;
      if (gap == 2 && junk) begin
        start = ($urandom_range(0, 7) == 0);
        len_i = CW'($urandom);
      end
      rdy = $urandom_range(0, 1);
      cyc();
      start = 1'b0;
      if (beats < len) begin
        check("acc_busy", 78'(busy), 78'(1));
        check("acc_vld", 78'(vld_o), 78'(0));
      end
    end
    vld_i = 1'b0;
    last_exp = pack(s0, s1);
    check("res_vld", 78'(vld_o), 78'(1));
    check("res_dout", dout, last_exp);
    check("res_busy", 78'(busy), 78'(1));
    for (int i = 0; i < hold; i++) begin
      rdy = 1'b0;
      start = junk && ((i == 0) || ($urandom_range(0, 1) == 1));
      junk_beat();
      cyc();
      check("hold_vld", 78'(vld_o), 78'(1));
      check("hold_dout", dout, last_exp);
    end
    rdy = 1'b1;
    start = junk && ($urandom_range(0, 1) == 1);
    junk_beat();
    cyc();
    start = 1'b0;
    vld_i = 1'b0;
    rdy = 1'b0;
    check("idle_vld", 78'(vld_o), 78'(0));
    check("idle_busy", 78'(busy), 78'(0));
    check("idle_dout", dout, last_exp);
    cyc();
    check("idle2_busy", 78'(busy), 78'(0));
  endtask

  initial begin
    cyc();
    check("rst_busy", 78'(busy), 78'(0));
    check("rst_vld", 78'(vld_o), 78'(0));
    check("rst_dout", dout, 78'(0));
    rst = 1'b0;
    cyc();

    q0 = '{1, 3, 5};
    q1 = '{2, 4, 6};
    run(3, 0, 0);
    check("basic", last_exp, {39'd12, 39'd9});

    q0 = '{M - 1, 2};
    q1 = '{M - 2, 5};
    run(2, 0, 0);
    check("wrap", last_exp, {39'd3, 39'd1});

    q0 = '{1, 1, 1, 1};
    q1 = '{1, 1, 1, 1};
    run(4, 1, 5);
    check("gaps", last_exp, {39'd4, 39'd4});

    run(0, 0, 2);
    check("zero", last_exp, 78'(0));

    start = 1'b1;
    len_i = 8'd5;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vld_i = 1'b1;
      din = pack(rnd_lane(), rnd_lane());
      cyc();
    end
    vld_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 78'(busy), 78'(0));
    check("mid_rst_vld", 78'(vld_o), 78'(0));
    check("mid_rst_dout", dout, 78'(0));
    cyc();
    rst = 1'b0;
    cyc();
    q0 = '{7};
    q1 = '{8};
    run(1, 0, 0);
    check("post_rst", last_exp, {39'd8, 39'd7});

    run(255, 0, 1);
    repeat (30) run($urandom_range(0, 12), 2, $urandom_range(0, 3));

`ifdef VPU2_ACC_CHK_EN
    junk = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    check("err_clr", 78'(err), 78'(0));
    vld_i = 1'b1;
    din = pack(1, 1);
    cyc();
    vld_i = 1'b0;
    check("err_idle_vld", 78'(err), 78'(1));
    run(2, 0, 0);
    check("err_sticky", 78'(err), 78'(1));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    check("err_rst", 78'(err), 78'(0));
    q0 = '{3};
    q1 = '{M};
    run(1, 0, 0);
    check("err_range", 78'(err), 78'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
